// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//   Single-entry instruction fetch stage. Holds the fetch pointer (fpc),
//   issues requests to an instruction memory that answers in the same cycle,
//   and registers the fetched word together with its address and address+4.
//   Jump/branch redirects reload the fetch pointer, squash the held
//   instruction and flag misaligned targets.
//
// Parameters
//   M         - PC / address width
//   RESET_PC  - first fetch address after reset
//
// Ports
//   clk, reset        - clock, synchronous active-high reset
//   imem_req          - fetch request (out)
//   imem_addr [M]     - fetch address, equals fpc (out)
//   imem_ack          - memory accepts and returns data this cycle (in)
//   imem_rdata [32]   - instruction word, valid with imem_ack (in)
//   branch, branch_target[M] - taken-branch redirect (in)
//   jump, jump_target[M]     - jump redirect, wins over branch (in)
//   stall             - downstream cannot take the current instruction (in)
//   instr [32]        - registered instruction (out)
//   instr_valid       - instr/pc/pc_plus4 hold a valid instruction (out)
//   pc, pc_plus4 [M]  - address of instr and its successor (out)
//   misalign          - one-cycle pulse after a redirect to a target with
//                       bits [1:0] != 0 (out)
//   fetch_state [2]   - debug view of the output stage state (out):
//                       0 EMPTY, 1 VALID, 2 FULL
//
// Handshake: a fetch transfers on a cycle where imem_req and imem_ack are
// both high (accept). The memory may hold imem_ack low to back-pressure; the
// address is then re-presented unchanged. On the output side instr_valid
// behaves as valid and !stall as ready: an instruction is consumed on a cycle
// with instr_valid=1 and stall=0, and is held unchanged while stall=1.
// -----------------------------------------------------------------------------
module fetch_unit #(
  parameter int unsigned    M        = 32,
  parameter logic [M-1:0]   RESET_PC = '0
) (
  input  logic          clk,
  input  logic          reset,
  output logic          imem_req,
  output logic [M-1:0]  imem_addr,
  input  logic          imem_ack,
  input  logic [31:0]   imem_rdata,
  input  logic          branch,
  input  logic [M-1:0]  branch_target,
  input  logic          jump,
  input  logic [M-1:0]  jump_target,
  input  logic          stall,
  output logic [31:0]   instr,
  output logic          instr_valid,
  output logic [M-1:0]  pc,
  output logic [M-1:0]  pc_plus4,
  output logic          misalign,
  output logic [1:0]    fetch_state
);

  // Output stage state. It is not stored separately: it is a view of
  // instr_valid qualified by stall, so it can never disagree with the
  // registered outputs.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    VALID = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t state;

  // Registered state
  logic [M-1:0] fpc_q;
  logic [31:0]  instr_q;
  logic         valid_q;
  logic [M-1:0] pc_q;
  logic [M-1:0] pc4_q;
  logic         misalign_q;

  // Next-state values
  logic [M-1:0] fpc_d;
  logic [31:0]  instr_d;
  logic         valid_d;
  logic [M-1:0] pc_d;
  logic [M-1:0] pc4_d;
  logic         misalign_d;

  // Request / redirect decode
  logic         redirect;
  logic [M-1:0] target;
  logic         accept;
  logic [M-1:0] fpc_inc;

  assign redirect = jump | branch;
  assign target   = jump ? jump_target : branch_target;
  // A redirect cycle never fetches: the old pointer is about to be discarded.
  assign imem_req = !redirect && (!valid_q || !stall);
  assign accept   = imem_req && imem_ack;
  // Wraps modulo 2^M by construction of the M-bit add.
  assign fpc_inc  = fpc_q + M'(4);

  always_comb begin
    if (!valid_q)   state = EMPTY;
    else if (stall) state = FULL;
    else            state = VALID;
  end

  // Next-state / output decode
  always_comb begin
    fpc_d      = fpc_q;
    instr_d    = instr_q;
    valid_d    = valid_q;
    pc_d       = pc_q;
    pc4_d      = pc4_q;
    misalign_d = 1'b0;

    if (redirect) begin
      // Squash whatever is held, even under stall; the low address bits are
      // forced to word alignment and the mismatch is only reported.
      fpc_d      = {target[M-1:2], 2'b00};
      valid_d    = 1'b0;
      misalign_d = |target[1:0];
    end else if (accept) begin
      instr_d = imem_rdata;
      pc_d    = fpc_q;
      pc4_d   = fpc_inc;
      valid_d = 1'b1;
      fpc_d   = fpc_inc;
    end else begin
      case (state)
        // Held instruction consumed and nothing new arrived.
        VALID:   valid_d = 1'b0;
        // FULL holds everything; EMPTY waits (fpc kept for retry).
        default: valid_d = valid_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fpc_q      <= RESET_PC;
      instr_q    <= '0;
      valid_q    <= 1'b0;
      pc_q       <= '0;
      pc4_q      <= '0;
      misalign_q <= 1'b0;
    end else begin
      fpc_q      <= fpc_d;
      instr_q    <= instr_d;
      valid_q    <= valid_d;
      pc_q       <= pc_d;
      pc4_q      <= pc4_d;
      misalign_q <= misalign_d;
    end
  end

  assign imem_addr   = fpc_q;
  assign instr       = instr_q;
  assign instr_valid = valid_q;
  assign pc          = pc_q;
  assign pc_plus4    = pc4_q;
  assign misalign    = misalign_q;
  assign fetch_state = state;

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
//   Bench for fetch_unit. A behavioural model tracks the fetch pointer and
//   the single output slot as plain integers; instruction memory is a pure
//   function of the address. Directed scenarios come first, then random
//   traffic on reset/redirect/stall/ack.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

  localparam int unsigned M = 32;
  localparam logic [31:0] RST_PC = 32'h0;

  // clock / reset block
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic          imem_req;
  logic [M-1:0]  imem_addr;
  logic          imem_ack;
  logic [31:0]   imem_rdata;
  logic          branch;
  logic [M-1:0]  branch_target;
  logic          jump;
  logic [M-1:0]  jump_target;
  logic          stall;
  logic [31:0]   instr;
  logic          instr_valid;
  logic [M-1:0]  pc;
  logic [M-1:0]  pc_plus4;
  logic          misalign;
  logic [1:0]    fetch_state;

  fetch_unit #(.M(M), .RESET_PC(RST_PC)) dut (
    .clk           (clk),
    .reset         (reset),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .branch        (branch),
    .branch_target (branch_target),
    .jump          (jump),
    .jump_target   (jump_target),
    .stall         (stall),
    .instr         (instr),
    .instr_valid   (instr_valid),
    .pc            (pc),
    .pc_plus4      (pc_plus4),
    .misalign      (misalign),
    .fetch_state   (fetch_state)
  );

  // Instruction memory contents: a fixed scramble of the address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  assign imem_rdata = mem_word(imem_addr);

  // scoreboard
  int vectors = 0;
  int miscompares = 0;
  logic [31:0] exp_q[$];

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // reference model state
  bit          m_init = 0;
  logic [31:0] m_fpc, m_instr, m_pc, m_pc4;
  bit          m_valid, m_mis;

  // One clock cycle with the currently driven inputs: check the
  // combinational request, advance the model, clock, check the registers.
  task automatic run_cycle();
    bit redir, req, acc;
    logic [31:0] tgt;
    #1;
    redir = jump || branch;
    tgt   = jump ? jump_target : branch_target;
    req   = !redir && (!m_valid || !stall);
    acc   = req && imem_ack;
    if (m_init) begin
      check_val("imem_req", 64'(imem_req), 64'(req));
      check_val("imem_addr", 64'(imem_addr), 64'(m_fpc));
      check_val("fetch_state", 64'(fetch_state),
                64'(!m_valid ? 2'd0 : (stall ? 2'd2 : 2'd1)));
    end
    if (reset) begin
      m_fpc = RST_PC; m_valid = 0; m_instr = 0; m_pc = 0; m_pc4 = 0; m_mis = 0;
      m_init = 1;
      exp_q.delete();
    end else if (m_init) begin
      m_mis = 0;
      if (redir) begin
        m_fpc   = tgt & ~32'd3;
        m_valid = 0;
        m_mis   = (tgt % 4) != 0;
      end else if (acc) begin
        exp_q.push_back(mem_word(m_fpc));
        m_pc    = m_fpc;
        m_pc4   = m_fpc + 32'd4;
        m_instr = mem_word(m_fpc);
        m_valid = 1;
        m_fpc   = m_fpc + 32'd4;
      end else if (!stall) begin
        m_valid = 0;
      end
    end
    @(posedge clk);
    #1;
    if (m_init) begin
      check_val("instr_valid", 64'(instr_valid), 64'(m_valid));
      check_val("instr", 64'(instr), 64'(m_instr));
      check_val("pc", 64'(pc), 64'(m_pc));
      check_val("pc_plus4", 64'(pc_plus4), 64'(m_pc4));
      check_val("misalign", 64'(misalign), 64'(m_mis));
      if (exp_q.size() != 0) check_val("fetched_word", 64'(instr), 64'(exp_q.pop_front()));
    end
  endtask

  // driver task
  task automatic drive(input bit rst, input bit br, input logic [31:0] bt,
                       input bit jp, input logic [31:0] jt, input bit st, input bit ack);
    reset = rst; branch = br; branch_target = bt; jump = jp; jump_target = jt;
    stall = st; imem_ack = ack;
    run_cycle();
  endtask

  initial begin
    reset = 1; branch = 0; branch_target = 0; jump = 0; jump_target = 0;
    stall = 0; imem_ack = 0;
    @(negedge clk);

    // reset, then streaming fetch 0,4,8,12
    drive(1, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 1, 1);
    for (int i = 0; i < 3; i++) drive(0, 0, 0, 0, 0, 0, 1);
    check_val("pc_at_8", 64'(pc), 64'(32'd8));
    // hold pc=8 for three stall cycles, then resume at 12
    for (int i = 0; i < 3; i++) drive(0, 0, 0, 0, 0, 1, 1);
    drive(0, 0, 0, 0, 0, 0, 1);
    check_val("pc_resume_12", 64'(pc), 64'(32'd12));
    // memory back-pressure keeps the address
    for (int i = 0; i < 2; i++) drive(0, 0, 0, 0, 0, 0, 0);
    // jump beats branch
    drive(0, 1, 32'h40, 1, 32'h80, 0, 1);
    check_val("redirect_addr", 64'(imem_addr), 64'(32'h80));
    drive(0, 0, 0, 0, 0, 0, 1);
    // misaligned jump target
    drive(0, 0, 32'h41, 1, 32'h103, 1, 1);
    check_val("misalign_pulse", 64'(misalign), 64'(1));
    drive(0, 0, 0, 0, 0, 0, 1);
    check_val("misalign_clear", 64'(misalign), 64'(0));
    // branch alone with a misaligned unselected jump target
    drive(0, 1, 32'h200, 0, 32'h3, 0, 1);
    // wrap at the top of the address space
    drive(0, 1, 32'hFFFF_FFFC, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 0, 0, 1);
    check_val("wrap_pc4", 64'(pc_plus4), 64'(0));
    check_val("wrap_addr", 64'(imem_addr), 64'(0));
    // reset while FULL
    drive(0, 0, 0, 0, 0, 1, 1);
    drive(1, 1, 32'h40, 0, 0, 1, 1);
    check_val("reset_full_valid", 64'(instr_valid), 64'(0));
    check_val("reset_full_addr", 64'(imem_addr), 64'(RST_PC));

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      bit r, b, j, s, a;
      logic [31:0] bt, jt;
      r  = ($urandom_range(0, 99) < 2);
      b  = ($urandom_range(0, 99) < 10);
      j  = ($urandom_range(0, 99) < 8);
      s  = ($urandom_range(0, 99) < 30);
      a  = ($urandom_range(0, 99) < 75);
      bt = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
      jt = $urandom_range(0, 4095);
      drive(r, b, bt, j, jt, s, a);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
